// File: rtl/hms_clock.sv
// BCD time-of-day counter driven by a 1 Hz toggle, with a two-button hour/minute set FSM.
// Optional alarm compare and latch are built when HMS_ALARM_EN is defined.
module hms_clock #(
    parameter int SYNC_STAGES = 2,
    parameter bit H24         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_in,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic       pm,
    output logic [1:0] set_mode,
    output logic       sec_tick
`ifdef HMS_ALARM_EN
    ,
    input  logic       alarm_on,
    input  logic [7:0] alarm_hr_bcd,
    input  logic [7:0] alarm_min_bcd,
    input  logic       alarm_pm,
    output logic       alarm
`endif
);

    typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_e;

    mode_e                  state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   hist, sync_out, tick;
    logic                   pm_q, pm_d, tick_d;
    logic [7:0]             sec_d, min_d, hr_d;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        if (H24 && v == 8'h23) return 8'h00;
        if (!H24 && v == 8'h12) return 8'h01;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // vld_pipe masks the edge detector until history holds a real sample,
    // so the pulse_in level seen at reset release never looks like an edge.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign tick     = (sync_out ^ hist) & vld_pipe[SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            vld_pipe <= '0;
            hist     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            hist     <= sync_out;
        end
    end

    always_comb begin
        state_d = state;
        sec_d   = sec_bcd;
        min_d   = min_bcd;
        hr_d    = hr_bcd;
        pm_d    = pm_q;
        tick_d  = 1'b0;
        case (state)
            RUN: begin
                if (mode_btn) begin
                    state_d = SET_HR;
                    sec_d   = 8'h00;
                end else if (tick) begin
                    tick_d = 1'b1;
                    sec_d  = inc60(sec_bcd);
                    if (sec_bcd == 8'h59) min_d = inc60(min_bcd);
                    if (sec_bcd == 8'h59 && min_bcd == 8'h59) begin
                        hr_d = inc_hr(hr_bcd);
                        pm_d = pm_q ^ (!H24 && hr_bcd == 8'h11);
                    end
                end
            end
            SET_HR: begin
                if (mode_btn) state_d = SET_MIN;
                else if (inc_btn) begin
                    hr_d = inc_hr(hr_bcd);
                    pm_d = pm_q ^ (!H24 && hr_bcd == 8'h11);
                end
            end
            SET_MIN: begin
                if (mode_btn) state_d = RUN;
                else if (inc_btn) min_d = inc60(min_bcd);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            sec_bcd  <= 8'h00;
            min_bcd  <= 8'h00;
            hr_bcd   <= H24 ? 8'h00 : 8'h12;
            pm_q     <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_d;
            sec_bcd  <= sec_d;
            min_bcd  <= min_d;
            hr_bcd   <= hr_d;
            pm_q     <= pm_d;
            sec_tick <= tick_d;
        end
    end

    assign pm       = H24 ? 1'b0 : pm_q;
    assign set_mode = state;

`ifdef HMS_ALARM_EN
    logic match, ack;
    // Compare against the post-tick time so alarm rises on the same edge as the counters.
    assign match = tick_d && sec_d == 8'h00 && min_d == alarm_min_bcd &&
                   hr_d == alarm_hr_bcd && (H24 || pm_d == alarm_pm);
    assign ack   = state == RUN && inc_btn && !mode_btn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          alarm <= 1'b0;
        else if (!alarm_on) alarm <= 1'b0;
        else if (match)     alarm <= 1'b1;
        else if (ack)       alarm <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_hms_clock.sv
// Directed bench for hms_clock: one 24 h instance and one 12 h instance on separate stimulus.
// Alarm scenario is compiled only when HMS_ALARM_EN is defined.
module tb_hms_clock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       pulse_in = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
    logic       p12 = 1'b0, mode12 = 1'b0, inc12 = 1'b0;
    logic [7:0] sec_bcd, min_bcd, hr_bcd, sec12, min12, hr12;
    logic       pm, pm12, sec_tick, tick12;
    logic [1:0] set_mode, mode_o12;
`ifdef HMS_ALARM_EN
    logic       alarm_on = 1'b0, alarm_pm = 1'b0, alarm, alarm12;
    logic [7:0] alarm_hr_bcd = 8'h00, alarm_min_bcd = 8'h00;
    logic       alarm_on12 = 1'b0, alarm_pm12 = 1'b0;
    logic [7:0] alarm_hr12 = 8'h00, alarm_min12 = 8'h00;
`endif

    int passed = 0, total = 0;

    hms_clock #(.SYNC_STAGES(2), .H24(1'b1)) u_dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd), .pm(pm),
        .set_mode(set_mode), .sec_tick(sec_tick)
`ifdef HMS_ALARM_EN
        , .alarm_on(alarm_on), .alarm_hr_bcd(alarm_hr_bcd), .alarm_min_bcd(alarm_min_bcd),
        .alarm_pm(alarm_pm), .alarm(alarm)
`endif
    );

    hms_clock #(.SYNC_STAGES(2), .H24(1'b0)) u_dut12 (
        .clk(clk), .reset(reset), .pulse_in(p12), .mode_btn(mode12), .inc_btn(inc12),
        .sec_bcd(sec12), .min_bcd(min12), .hr_bcd(hr12), .pm(pm12),
        .set_mode(mode_o12), .sec_tick(tick12)
`ifdef HMS_ALARM_EN
        , .alarm_on(alarm_on12), .alarm_hr_bcd(alarm_hr12), .alarm_min_bcd(alarm_min12),
        .alarm_pm(alarm_pm12), .alarm(alarm12)
`endif
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic press(input bit w12, input bit m, input bit i);
        if (w12) begin mode12 = m; inc12 = i; end
        else begin mode_btn = m; inc_btn = i; end
        step();
        mode_btn = 1'b0; inc_btn = 1'b0; mode12 = 1'b0; inc12 = 1'b0;
    endtask

    task automatic incs(input bit w12, input int n);
        for (int i = 0; i < n; i++) press(w12, 1'b0, 1'b1);
    endtask

    // One second: toggle the pulse and give the synchroniser time to deliver it.
    task automatic toggle(input bit w12, output int strobes);
        strobes = 0;
        if (w12) p12 = ~p12; else pulse_in = ~pulse_in;
        for (int i = 0; i < 4; i++) begin
            step();
            if (w12 ? tick12 : sec_tick) strobes++;
        end
    endtask

    task automatic toggles(input bit w12, input int n);
        int s;
        for (int i = 0; i < n; i++) toggle(w12, s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        int strobes;
        do_reset();
        toggles(0, 3);
        total++; if (sec_bcd !== 8'h03) $display("FAIL reset_precount sec=%h exp=03", sec_bcd); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h000000) $display("FAIL reset_async_24 time=%h exp=000000", {hr_bcd, min_bcd, sec_bcd}); else passed++;
        total++; if (set_mode !== 2'b00 || sec_tick !== 1'b0) $display("FAIL reset_async_mode mode=%b tick=%b exp=00/0", set_mode, sec_tick); else passed++;
        total++; if ({hr12, min12, sec12} !== 24'h120000 || pm12 !== 1'b0) $display("FAIL reset_async_12 time=%h pm=%b exp=120000/0", {hr12, min12, sec12}, pm12); else passed++;
        step(); step();
        reset = 1'b0; // pulse_in is 1 here
        strobes = 0;
        for (int i = 0; i < 8; i++) begin step(); if (sec_tick) strobes++; end
        total++; if (strobes !== 0 || sec_bcd !== 8'h00) $display("FAIL reset_release strobes=%0d sec=%h exp=0/00", strobes, sec_bcd); else passed++;
    endtask

    task automatic test_latency();
        int at, cnt;
        pulse_in = 1'b0;
        do_reset();
        for (int e = 0; e < 2; e++) begin
            pulse_in = ~pulse_in;
            at = 0; cnt = 0;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (sec_tick) begin cnt++; if (at == 0) at = k; end
                if (k == 2) begin
                    total++; if (sec_bcd !== 8'(e)) $display("FAIL latency_early%0d sec=%h exp=%0d", e, sec_bcd, e); else passed++;
                end
            end
            total++; if (at !== 3 || cnt !== 1) $display("FAIL latency_strobe%0d at=%0d cnt=%0d exp=3/1", e, at, cnt); else passed++;
            total++; if (sec_bcd !== 8'(e + 1)) $display("FAIL latency_sec%0d sec=%h exp=%0d", e, sec_bcd, e + 1); else passed++;
        end
    endtask

    task automatic test_set_fsm();
        int s;
        do_reset();
        toggles(0, 2);
        press(0, 1'b1, 1'b0);
        total++; if (set_mode !== 2'b01 || sec_bcd !== 8'h00) $display("FAIL set_enter mode=%b sec=%h exp=01/00", set_mode, sec_bcd); else passed++;
        incs(0, 5);
        toggle(0, s);
        total++; if (hr_bcd !== 8'h05 || sec_bcd !== 8'h00 || s !== 0) $display("FAIL set_hr hr=%h sec=%h strobes=%0d exp=05/00/0", hr_bcd, sec_bcd, s); else passed++;
        press(0, 1'b1, 1'b0);
        total++; if (set_mode !== 2'b10) $display("FAIL set_min_enter mode=%b exp=10", set_mode); else passed++;
        incs(0, 61);
        toggle(0, s);
        total++; if (min_bcd !== 8'h01 || hr_bcd !== 8'h05 || s !== 0) $display("FAIL set_min min=%h hr=%h strobes=%0d exp=01/05/0", min_bcd, hr_bcd, s); else passed++;
        press(0, 1'b1, 1'b0);
        total++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h050100 || set_mode !== 2'b00) $display("FAIL set_exit time=%h mode=%b exp=050100/00", {hr_bcd, min_bcd, sec_bcd}, set_mode); else passed++;
        toggle(0, s);
        total++; if (sec_bcd !== 8'h01 || s !== 1) $display("FAIL set_resume sec=%h strobes=%0d exp=01/1", sec_bcd, s); else passed++;
        press(0, 1'b0, 1'b1);
        total++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h050101) $display("FAIL run_inc time=%h exp=050101", {hr_bcd, min_bcd, sec_bcd}); else passed++;
    endtask

    task automatic test_collision();
        do_reset();
        press(0, 1'b1, 1'b0);
        incs(0, 2);
        press(0, 1'b1, 1'b1);
        total++; if (set_mode !== 2'b10 || hr_bcd !== 8'h02 || min_bcd !== 8'h00) $display("FAIL coll_mode_inc mode=%b hr=%h min=%h exp=10/02/00", set_mode, hr_bcd, min_bcd); else passed++;
        pulse_in = ~pulse_in;
        step(); step();
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
        step(); step();
        total++; if (min_bcd !== 8'h01 || sec_bcd !== 8'h00 || sec_tick !== 1'b0) $display("FAIL coll_tick_inc min=%h sec=%h tick=%b exp=01/00/0", min_bcd, sec_bcd, sec_tick); else passed++;
    endtask

    task automatic test_rollover24();
        int s;
        do_reset();
        press(0, 1'b1, 1'b0); incs(0, 23);
        press(0, 1'b1, 1'b0); incs(0, 59);
        press(0, 1'b1, 1'b0);
        toggles(0, 59);
        total++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h235959) $display("FAIL roll24_pre time=%h exp=235959", {hr_bcd, min_bcd, sec_bcd}); else passed++;
        toggle(0, s);
        total++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h000000 || pm !== 1'b0) $display("FAIL roll24 time=%h pm=%b exp=000000/0", {hr_bcd, min_bcd, sec_bcd}, pm); else passed++;
    endtask

    task automatic test_rollover12();
        int s;
        do_reset();
        press(1, 1'b1, 1'b0); incs(1, 11);
        total++; if (hr12 !== 8'h11 || pm12 !== 1'b0) $display("FAIL set12_hr hr=%h pm=%b exp=11/0", hr12, pm12); else passed++;
        press(1, 1'b1, 1'b0); incs(1, 59);
        press(1, 1'b1, 1'b0);
        toggles(1, 59);
        total++; if ({hr12, min12, sec12} !== 24'h115959 || pm12 !== 1'b0) $display("FAIL roll12_pre_am time=%h pm=%b exp=115959/0", {hr12, min12, sec12}, pm12); else passed++;
        toggle(1, s);
        total++; if ({hr12, min12, sec12} !== 24'h120000 || pm12 !== 1'b1) $display("FAIL roll12_noon time=%h pm=%b exp=120000/1", {hr12, min12, sec12}, pm12); else passed++;
        press(1, 1'b1, 1'b0); press(1, 1'b1, 1'b0); incs(1, 59);
        press(1, 1'b1, 1'b0);
        toggles(1, 59);
        total++; if ({hr12, min12, sec12} !== 24'h125959 || pm12 !== 1'b1) $display("FAIL roll12_pre_pm time=%h pm=%b exp=125959/1", {hr12, min12, sec12}, pm12); else passed++;
        toggle(1, s);
        total++; if ({hr12, min12, sec12} !== 24'h010000 || pm12 !== 1'b1) $display("FAIL roll12_one time=%h pm=%b exp=010000/1", {hr12, min12, sec12}, pm12); else passed++;
    endtask

`ifdef HMS_ALARM_EN
    task automatic test_alarm();
        int s;
        do_reset();
        alarm_hr_bcd = 8'h00; alarm_min_bcd = 8'h01; alarm_on = 1'b1;
        toggles(0, 59);
        total++; if (alarm !== 1'b0 || sec_bcd !== 8'h59) $display("FAIL alarm_pre alarm=%b sec=%h exp=0/59", alarm, sec_bcd); else passed++;
        toggle(0, s);
        total++; if (alarm !== 1'b1 || min_bcd !== 8'h01) $display("FAIL alarm_fire alarm=%b min=%h exp=1/01", alarm, min_bcd); else passed++;
        press(0, 1'b0, 1'b1);
        total++; if (alarm !== 1'b0 || {hr_bcd, min_bcd, sec_bcd} !== 24'h000100) $display("FAIL alarm_ack alarm=%b time=%h exp=0/000100", alarm, {hr_bcd, min_bcd, sec_bcd}); else passed++;
        alarm_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_set_fsm();
        test_collision();
        test_rollover24();
        test_rollover12();
`ifdef HMS_ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
